audio_sdm_dac: RTL and testbench
================================

// Module: audio_sdm_dac
// PURPOSE
//  Output stage for the machine's sound path. Consumes the 11-bit signed volume-scaled sample
//  produced by the data controller (audioOut) on each sound-buffer fetch. Produces two outputs:
//  a DC-blocked 16-bit PCM stream for the HDMI/I2S audio path, and a 1-bit second-order
//  sigma-delta bitstream for the analog pin, which is followed by an RC filter on the board.
// PARAMETERS
//  IN_W       11  input sample width, two's complement
//  OUT_W      16  PCM output width; also sets the sigma-delta full-scale value FS = 2^(OUT_W-1)
//  DCB_SHIFT  10  DC-blocker pole: y -= y>>>DCB_SHIFT
//  INT_W      20  sigma-delta integrator width, signed
// PORTS
//  clk            in   1      16 MHz system clock
//  reset          in   1      synchronous, active-high
//  clk_en         in   1      8 MHz enable (clk8_en_p); modulator advances only when high
//  sample_in      in   IN_W   signed sample; valid on the cycle sample_strobe is high
//  sample_strobe  in   1      1-clk pulse per new sample (~22 kHz); the top level drives it
//                             from (loadSound & cycleReady) delayed by one clk
//  mute           in   1      forces the modulator input to 0; PCM path is unaffected
//  pcm_out        out  OUT_W  signed DC-blocked sample
//  pcm_valid      out  1      1-clk pulse when pcm_out updates
//  pdm_out        out  1      sigma-delta bitstream (1 = +FS, 0 = -FS)
// BEHAVIOUR
//  Reset (synchronous, active-high, dominates every other input):
//   - x_prev, y, pcm_out, int1, int2, pipeline valid bits are cleared to 0.
//   - pdm_out = 0 and pcm_valid = 0 on the first clk after reset is sampled.
//   - Reset asserted mid-pipeline discards the in-flight sample; no pcm_valid is emitted for it.
//  PCM pipeline (independent of clk_en), 2 stages:
//   - S1, on strobe: xs = sample_in sign-extended and shifted left (OUT_W-IN_W).
//     Compute d = xs - x_prev at OUT_W+2 bits. Update x_prev <= xs.
//   - S2: y <= y + d - (y>>>DCB_SHIFT), held at OUT_W+8 bits signed.
//     pcm_out <= sat(y), saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//     Internal y keeps the unsaturated value. pcm_valid pulses in this same cycle.
//   - Latency: pcm_valid is high exactly 2 clks after sample_strobe.
//   - Strobes are spaced >= 4 clks apart. Back-to-back strobes are still processed in order,
//     because the pipeline is fully pipelined.
//  Sigma-delta modulator (advances only on clk_en):
//   - u = mute ? 0 : pcm_out. fb = pdm_out ? +FS : -FS.
//   - int1 <= sat(int1 + u - fb). int2 <= sat(int2 + int1_new - fb).
//     Both saturate to +/-(2^(INT_W-1)-1).
//   - pdm_out <= (int2_new >= 0).
//   - pcm_out changing in the same cycle as clk_en: the modulator uses the pcm_out value
//     registered before the edge. The new value takes effect on the next enabled cycle.
//   - With clk_en low, all modulator state holds.
//  Arithmetic: all signed; arithmetic shifts only. No wrap-around permitted anywhere.
//  Every overflow point listed above saturates.
// TESTING
//  1. Assert reset for 3 clks with strobes and clk_en active
//     -> pcm_out=0, pcm_valid=0, pdm_out=0 throughout, and 1 clk after release.
//  2. sample_in=0, strobe every 728 clks, 4096 clk_en cycles
//     -> pcm_out=0 always; pdm_out ones count = 2048 +/-2.
//  3. From reset, strobe sample_in=11'sd1023, then 11'sd1023 again
//     -> pcm_out=32736 then 32705; pcm_valid exactly 2 clks after each strobe.
//  4. Strobe -1024, then +1023 (d = 65504 after the -1024 step)
//     -> pcm_out saturates at 32767; next strobe of +1023 decays toward 0, no sign flip.
//  5. Force pcm_out steady at +16384 (mute=0) and run 4096 clk_en cycles
//     -> ones ratio 0.75 +/-0.01. With mute=1 -> ratio 0.50 +/-0.01.
//  6. Assert reset 1 clk after a strobe
//     -> no pcm_valid for that sample. Then strobe +1023 -> pcm_out=32736 (x_prev was cleared).

Source files
------------

// File: rtl/audio_sdm_dac.sv
// audio_sdm_dac
// Sound output stage: a DC-blocked PCM stream for the digital audio path and a
// second-order 1-bit sigma-delta bitstream for the RC-filtered analog pin.
// The PCM path runs every clk; the modulator only advances on clk_en.
// All arithmetic is signed with arithmetic shifts, and every overflow point saturates.
module audio_sdm_dac #(
   parameter int IN_W      = 11,
   parameter int OUT_W     = 16,
   parameter int DCB_SHIFT = 10,
   parameter int INT_W     = 20
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clk_en,
   input  logic signed [IN_W-1:0]  sample_in,
   input  logic                    sample_strobe,
   input  logic                    mute,
   output logic signed [OUT_W-1:0] pcm_out,
   output logic                    pcm_valid,
   output logic                    pdm_out
);

   // ------------------------------------------------------------------
   // Widths and constants
   // ------------------------------------------------------------------
   localparam int SHL   = OUT_W - IN_W;  // input is left-justified into the PCM word
   localparam int D_W   = OUT_W + 2;     // difference of two OUT_W values never overflows here
   localparam int Y_W   = OUT_W + 8;     // DC-blocker state, headroom above the PCM range
   localparam int YS_W  = Y_W + 2;       // un-saturated blocker sum
   localparam int ACC_W = INT_W + 2;     // un-saturated integrator sum
   localparam int ORDER = 2;             // number of cascaded integrators

   localparam logic signed [YS_W-1:0]  Y_MAX   = {3'b000, {(Y_W-1){1'b1}}};
   localparam logic signed [YS_W-1:0]  Y_MIN   = {3'b111, {(Y_W-1){1'b0}}};
   localparam logic signed [Y_W-1:0]   PCM_MAX = {{(Y_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [Y_W-1:0]   PCM_MIN = {{(Y_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
   // integrators clip symmetrically to +/-(2^(INT_W-1)-1)
   localparam logic signed [ACC_W-1:0] INT_MAX = {3'b000, {(INT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] INT_MIN = {3'b111, {(INT_W-2){1'b0}}, 1'b1};
   // feedback full scale FS = 2^(OUT_W-1)
   localparam logic signed [ACC_W-1:0] FS_POS  = {{(ACC_W-OUT_W){1'b0}}, 1'b1, {(OUT_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] FS_NEG  = -FS_POS;

   // ------------------------------------------------------------------
   // PCM stage 1: scale the new sample and form the first difference
   // ------------------------------------------------------------------
   logic signed [OUT_W-1:0] xs_ext;
   logic signed [OUT_W-1:0] xs;
   logic signed [OUT_W-1:0] x_prev_q;
   logic signed [D_W-1:0]   d_d;
   logic signed [D_W-1:0]   d_q;
   logic                    s1_valid_q;

   assign xs_ext = OUT_W'(sample_in);
   assign xs     = xs_ext <<< SHL;
   assign d_d    = D_W'(xs) - D_W'(x_prev_q);

   // Stage 1 registers: capture the difference and remember the sample on each strobe
   always_ff @(posedge clk) begin
      if (reset) begin
         x_prev_q   <= '0;
         d_q        <= '0;
         s1_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= sample_strobe;
         if (sample_strobe) begin
            x_prev_q <= xs;
            d_q      <= d_d;
         end
      end
   end

   // ------------------------------------------------------------------
   // PCM stage 2: leaky integrator y += d - y>>>DCB_SHIFT, then clip to PCM range
   // ------------------------------------------------------------------
   logic signed [Y_W-1:0]   y_q;
   logic signed [Y_W-1:0]   y_d;
   logic signed [YS_W-1:0]  y_sum;
   logic signed [OUT_W-1:0] pcm_d;
   logic signed [OUT_W-1:0] pcm_q;
   logic                    pcm_valid_q;

   // Blocker update with saturation of the wide state and of the PCM word
   always_comb begin
      y_sum = YS_W'(y_q) + YS_W'(d_q) - YS_W'(y_q >>> DCB_SHIFT);
      if (y_sum > Y_MAX) begin
         y_d = Y_MAX[Y_W-1:0];
      end else if (y_sum < Y_MIN) begin
         y_d = Y_MIN[Y_W-1:0];
      end else begin
         y_d = y_sum[Y_W-1:0];
      end

      if (y_d > PCM_MAX) begin
         pcm_d = PCM_MAX[OUT_W-1:0];
      end else if (y_d < PCM_MIN) begin
         pcm_d = PCM_MIN[OUT_W-1:0];
      end else begin
         pcm_d = y_d[OUT_W-1:0];
      end
   end

   // Stage 2 registers: y keeps the unclipped value, pcm_out the clipped one
   always_ff @(posedge clk) begin
      if (reset) begin
         y_q         <= '0;
         pcm_q       <= '0;
         pcm_valid_q <= 1'b0;
      end else begin
         pcm_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            y_q   <= y_d;
            pcm_q <= pcm_d;
         end
      end
   end

   assign pcm_out   = pcm_q;
   assign pcm_valid = pcm_valid_q;

   // ------------------------------------------------------------------
   // Sigma-delta modulator: cascade of clipping integrators, 1-bit quantizer
   // ------------------------------------------------------------------
   logic signed [ACC_W-1:0] u_ext;
   logic signed [ACC_W-1:0] fb;
   logic                    pdm_q;
   logic                    pdm_d;

   // Modulator input; reads the already-registered pcm word so a same-edge update lands next time
   always_comb begin
      u_ext = mute ? '0 : ACC_W'(pcm_q);
   end

   assign fb = pdm_q ? FS_POS : FS_NEG;

   genvar gi;
   generate
      for (gi = 0; gi < ORDER; gi++) begin : gen_int
         logic signed [INT_W-1:0] int_q;
         logic signed [INT_W-1:0] int_d;
         logic signed [ACC_W-1:0] stage_in;
         logic signed [ACC_W-1:0] acc;

         // first integrator sees the audio, later ones see the previous integrator's new value
         if (gi == 0) begin : g_first
            assign stage_in = u_ext;
         end else begin : g_chain
            assign stage_in = ACC_W'(gen_int[gi-1].int_d);
         end

         // Integrator next value: add input, subtract feedback, clip symmetrically
         always_comb begin
            acc = ACC_W'(int_q) + stage_in - fb;
            if (acc > INT_MAX) begin
               int_d = INT_MAX[INT_W-1:0];
            end else if (acc < INT_MIN) begin
               int_d = INT_MIN[INT_W-1:0];
            end else begin
               int_d = acc[INT_W-1:0];
            end
         end

         // Integrator state advances only on the modulator enable
         always_ff @(posedge clk) begin
            if (reset) begin
               int_q <= '0;
            end else if (clk_en) begin
               int_q <= int_d;
            end
         end
      end
   endgenerate

   // quantizer: 1 when the last integrator's new value is non-negative
   assign pdm_d = ~gen_int[ORDER-1].int_d[INT_W-1];

   // Output bit register, held while the enable is low
   always_ff @(posedge clk) begin
      if (reset) begin
         pdm_q <= 1'b0;
      end else if (clk_en) begin
         pdm_q <= pdm_d;
      end
   end

   assign pdm_out = pdm_q;

endmodule

// File: tb/tb_audio_sdm_dac.sv
// tb_audio_sdm_dac
// Randomized and directed stimulus for audio_sdm_dac, checked every cycle against
// an arithmetic reference model (scheduled PCM results plus integer modulator).
module tb_audio_sdm_dac;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               clk_en = 1'b0;
   logic signed [10:0] sample_in = '0;
   logic               sample_strobe = 1'b0;
   logic               mute = 1'b0;
   logic signed [15:0] pcm_out;
   logic               pcm_valid;
   logic               pdm_out;

   audio_sdm_dac dut (
      .clk          (clk),
      .reset        (reset),
      .clk_en       (clk_en),
      .sample_in    (sample_in),
      .sample_strobe(sample_strobe),
      .mute         (mute),
      .pcm_out      (pcm_out),
      .pcm_valid    (pcm_valid),
      .pdm_out      (pdm_out)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_range(input string nm, input longint act, input longint lo, input longint hi);
      total++;
      if (act < lo || act > hi) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
      end
   endtask

   function automatic longint clamp(input longint v, input longint lo, input longint hi);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      longint due;
      longint val;
   } ev_t;

   ev_t    pend[$];
   longint m_cycle = 0;
   longint m_xprev = 0;
   longint m_y     = 0;
   longint m_pcm   = 0;
   bit     m_valid = 1'b0;
   longint m_i1    = 0;
   longint m_i2    = 0;
   bit     m_pdm   = 1'b0;
   bit     chk_en  = 1'b0;
   bit     en_last = 1'b0;
   int     en_cnt  = 0;
   int     ones_cnt = 0;

   localparam longint FS   = 32768;
   localparam longint IMAX = 524287;

   always @(posedge clk) begin
      longint u, fb, xs, d;
      // pdm_out still holds the value produced by the previous enabled edge
      if (en_last) begin
         en_cnt++;
         if (pdm_out) ones_cnt++;
      end
      en_last = clk_en && !reset;
      m_cycle++;
      if (reset) begin
         pend.delete();
         m_xprev = 0; m_y = 0; m_pcm = 0; m_valid = 1'b0;
         m_i1 = 0; m_i2 = 0; m_pdm = 1'b0;
         chk_en = 1'b1;
      end else begin
         if (clk_en) begin
            u    = mute ? 0 : m_pcm;
            fb   = m_pdm ? FS : -FS;
            m_i1 = clamp(m_i1 + u - fb, -IMAX, IMAX);
            m_i2 = clamp(m_i2 + m_i1 - fb, -IMAX, IMAX);
            m_pdm = (m_i2 >= 0);
         end
         m_valid = 1'b0;
         if (pend.size() > 0 && pend[0].due == m_cycle) begin
            m_pcm   = pend[0].val;
            m_valid = 1'b1;
            void'(pend.pop_front());
         end
         if (sample_strobe) begin
            xs      = longint'(sample_in) * 32;
            d       = xs - m_xprev;
            m_xprev = xs;
            m_y     = clamp(m_y + d - (m_y >>> 10), -(64'sd1 <<< 23), (64'sd1 <<< 23) - 1);
            pend.push_back('{due: m_cycle + 1, val: clamp(m_y, -32768, 32767)});
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_pcm_valid", pcm_valid, m_valid);
         check("cyc_pcm_out", pcm_out, m_pcm);
         check("cyc_pdm_out", pdm_out, m_pdm);
      end
   end

   // ---------------- clk_en generator ----------------
   int en_mode = 0;  // 0 off, 1 alternate (8 MHz), 2 random
   always @(negedge clk) begin
      case (en_mode)
         1:       clk_en = ~clk_en;
         2:       clk_en = 1'($urandom_range(0, 1));
         default: clk_en = 1'b0;
      endcase
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // one-cycle strobe; returns at the negedge where the strobe drops
   task automatic strobe(input logic signed [10:0] s);
      @(negedge clk);
      sample_in     = s;
      sample_strobe = 1'b1;
      @(negedge clk);
      sample_strobe = 1'b0;
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      reset = 1'b1;
      tick(n);
      reset = 1'b0;
   endtask

   // run until n enabled cycles elapse; optional zero-sample strobes every per clks
   task automatic run_en(input int n, input int per, output int ones, output bit ok);
      int e0, o0, g;
      e0 = en_cnt; o0 = ones_cnt; g = 0;
      while ((en_cnt - e0) < n && g < 4 * n + 100) begin
         @(negedge clk);
         g++;
         sample_in     = '0;
         sample_strobe = (per > 0) && (g % per == 0);
      end
      sample_strobe = 1'b0;
      ones = ones_cnt - o0;
      ok   = ((en_cnt - e0) >= n);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int ones;
      bit ok;
      logic signed [10:0] s;
      int gap;

      // 1: reset held 3 clks with strobes and enable active
      en_mode = 1;
      @(negedge clk);
      reset = 1'b1; sample_strobe = 1'b1; sample_in = 11'sd300;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t1_rst_pcm_out", pcm_out, 0);
         check("t1_rst_pcm_valid", pcm_valid, 0);
         check("t1_rst_pdm_out", pdm_out, 0);
      end
      reset = 1'b0; sample_strobe = 1'b0;
      @(negedge clk);
      check("t1_rel_pcm_out", pcm_out, 0);
      check("t1_rel_pcm_valid", pcm_valid, 0);

      // 2: silence, strobes every 728 clks, 4096 enabled cycles
      do_reset(2);
      en_mode = 1;
      run_en(4096, 728, ones, ok);
      check("t2_en_budget", ok, 1);
      check("t2_pcm_zero", pcm_out, 0);
      check_range("t2_ones", ones, 2046, 2050);

      // 3: step response and first decay step
      en_mode = 0;
      do_reset(2);
      tick(2);
      strobe(11'sd1023);
      check("t3_valid_early", pcm_valid, 0);
      @(negedge clk);
      check("t3_valid_lat2", pcm_valid, 1);
      check("t3_pcm_first", pcm_out, 32736);
      tick(3);
      strobe(11'sd1023);
      @(negedge clk);
      check("t3_valid_second", pcm_valid, 1);
      check("t3_pcm_second", pcm_out, 32705);

      // 4: full negative step then full positive step saturates, then decays
      do_reset(2);
      tick(2);
      strobe(-11'sd1024);
      @(negedge clk);
      check("t4_pcm_neg", pcm_out, -32768);
      tick(3);
      strobe(11'sd1023);
      @(negedge clk);
      check("t4_pcm_sat", pcm_out, 32767);
      tick(3);
      strobe(11'sd1023);
      @(negedge clk);
      check("t4_pcm_decay", pcm_out, 32736);

      // 5: steady +16384 into the modulator, then muted
      do_reset(2);
      tick(2);
      strobe(11'sd512);
      @(negedge clk);
      check("t5_pcm_half", pcm_out, 16384);
      mute    = 1'b0;
      en_mode = 1;
      run_en(4096, 0, ones, ok);
      check("t5_en_budget", ok, 1);
      check_range("t5_ones_075", ones, 3072 - 41, 3072 + 41);
      mute = 1'b1;
      run_en(4096, 0, ones, ok);
      check("t5_en_budget_mute", ok, 1);
      check_range("t5_ones_050", ones, 2048 - 41, 2048 + 41);
      mute    = 1'b0;
      en_mode = 0;

      // 6: reset one clk after a strobe discards the sample and clears x_prev
      do_reset(2);
      tick(2);
      strobe(11'sd500);
      reset = 1'b1;
      @(negedge clk);
      check("t6_no_valid", pcm_valid, 0);
      reset = 1'b0;
      @(negedge clk);
      check("t6_no_valid_late", pcm_valid, 0);
      tick(2);
      strobe(11'sd1023);
      @(negedge clk);
      check("t6_pcm_after", pcm_out, 32736);

      // randomized traffic: samples, spacing, mute, enable, occasional reset
      en_mode = 2;
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 7))
            0:       s = -11'sd1024;
            1:       s = 11'sd1023;
            default: s = 11'($urandom_range(0, 2047));
         endcase
         if ($urandom_range(0, 9) == 0) mute = ~mute;
         strobe(s);
         gap = ($urandom_range(0, 3) == 0) ? 4 : int'($urandom_range(4, 40));
         tick(gap - 2);
         if ($urandom_range(0, 49) == 0) begin
            reset = 1'b1;
            tick(int'($urandom_range(1, 2)));
            reset = 1'b0;
         end
      end
      en_mode = 0;
      tick(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // absolute bound on simulation length
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
